// File: rtl/bdi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bdi_pkg
// Description : Shared constants, enums and mode helpers for the BDI
//               (Base-Delta-Immediate) decompressor slice.
//               - LINE_WORDS / PAYLOAD_W / LINE_W : line geometry
//               - MODE_* : bit positions inside the one-hot in_mode byte
//               - bdi_mode_e  : compact decoded mode used by the word lanes
//               - bdi_state_e : controller states
//               - mode_legal(), mode_decode() : mode validation / decoding
// Revision    : 1.0 - initial release
// ============================================================================
package bdi_pkg;

    localparam int LINE_WORDS = 16;
    localparam int PAYLOAD_W  = 256;
    localparam int LINE_W     = 512;
    localparam int WORD_W     = 32;
    localparam int MODE_W     = 8;

    // Bit positions inside the one-hot mode byte; bits 7:5 are reserved.
    localparam int MODE_ZERO   = 0;
    localparam int MODE_REPEAT = 1;
    localparam int MODE_B4D1   = 2;
    localparam int MODE_B8D1   = 3;
    localparam int MODE_B8D2   = 4;

    typedef enum logic [2:0] {
        BDI_ZERO   = 3'd0,
        BDI_REPEAT = 3'd1,
        BDI_B4D1   = 3'd2,
        BDI_B8D1   = 3'd3,
        BDI_B8D2   = 3'd4
    } bdi_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } bdi_state_e;

    // Legal means: reserved bits clear and exactly one of bits 4:0 set.
    function automatic logic mode_legal(input logic [MODE_W-1:0] mode);
        logic [4:0] m;
        m = mode[4:0];
        return (mode[7:5] == 3'b000) && (m != 5'b00000) &&
               ((m & (m - 5'd1)) == 5'b00000);
    endfunction

    // Illegal modes collapse to ZERO so the datapath naturally yields an
    // all-zero line; the error flag is tracked separately.
    function automatic bdi_mode_e mode_decode(input logic [MODE_W-1:0] mode);
        bdi_mode_e r;
        r = BDI_ZERO;
        if (mode_legal(mode)) begin
            if (mode[MODE_REPEAT])    r = BDI_REPEAT;
            else if (mode[MODE_B4D1]) r = BDI_B4D1;
            else if (mode[MODE_B8D1]) r = BDI_B8D1;
            else if (mode[MODE_B8D2]) r = BDI_B8D2;
            else                      r = BDI_ZERO;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bdi_word_lane.sv
`default_nettype none
// ============================================================================
// Module      : bdi_word_lane
// Description : Combinational decode of one 32-bit output word of a BDI line.
//   i_payload  : captured 256-bit compressed payload
//   i_mode     : decoded mode (illegal modes arrive as BDI_ZERO)
//   i_base_sel : per-element base select (1 = explicit base, 0 = zero base)
//   i_word_idx : output word index 0..15
//   o_word     : decoded word
// Revision    : 1.0 - initial release
// ============================================================================
module bdi_word_lane
    import bdi_pkg::*;
(
    input  logic [PAYLOAD_W-1:0]  i_payload,
    input  bdi_mode_e             i_mode,
    input  logic [LINE_WORDS-1:0] i_base_sel,
    input  logic [3:0]            i_word_idx,
    output logic [WORD_W-1:0]     o_word
);

    logic [2:0]  w_elem;
    logic [7:0]  w_off_b4d1;
    logic [7:0]  w_off_b8d1;
    logic [7:0]  w_off_b8d2;
    logic [7:0]  w_d8_word;
    logic [7:0]  w_d8_elem;
    logic [15:0] w_d16_elem;
    logic [31:0] w_base32;
    logic [63:0] w_base64;
    logic [63:0] w_delta64;
    logic [63:0] w_sum64;

    always_comb begin
        // In the 8-byte-base modes each 64-bit element covers two words.
        w_elem     = i_word_idx[3:1];

        // Delta bit offsets: B4D1 deltas start at bit 32, B8 deltas at 64.
        w_off_b4d1 = 8'd32 + {1'b0, i_word_idx, 3'b000};
        w_off_b8d1 = 8'd64 + {2'b00, w_elem, 3'b000};
        w_off_b8d2 = 8'd64 + {1'b0, w_elem, 4'b0000};

        w_d8_word  = i_payload[w_off_b4d1 +: 8];
        w_d8_elem  = i_payload[w_off_b8d1 +: 8];
        w_d16_elem = i_payload[w_off_b8d2 +: 16];

        w_base32   = i_base_sel[i_word_idx] ? i_payload[31:0] : 32'd0;
        w_base64   = i_base_sel[{1'b0, w_elem}] ? i_payload[63:0] : 64'd0;

        w_delta64  = (i_mode == BDI_B8D2) ? {{48{w_d16_elem[15]}}, w_d16_elem}
                                          : {{56{w_d8_elem[7]}}, w_d8_elem};
        // Full 64-bit add so a carry out of the low word reaches the high word.
        w_sum64    = w_base64 + w_delta64;

        o_word     = '0;
        case (i_mode)
            BDI_REPEAT: o_word = i_payload[31:0];
            BDI_B4D1:   o_word = w_base32 + {{24{w_d8_word[7]}}, w_d8_word};
            BDI_B8D1,
            BDI_B8D2:   o_word = i_word_idx[0] ? w_sum64[63:32] : w_sum64[31:0];
            default:    o_word = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bdi_decompressor.sv
`default_nettype none
// ============================================================================
// Module      : bdi_decompressor
// Description : Sequential BDI decompressor. Captures one compressed line in
//               IDLE, expands WORDS_PER_CYCLE words per cycle in EXPAND, then
//               presents the 512-bit line in DONE until out_ready.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : compressed line handshake (ready only in IDLE)
//   in_payload, in_mode,
//   in_base_sel, in_index  : compressed line fields
//   out_valid / out_ready  : decompressed line handshake
//   out_line, out_index    : decompressed line (word w at [32w+31:32w]), index
//   out_err                : illegal mode seen; qualified by out_valid
// Parameters  : WORDS_PER_CYCLE in {2,4,8,16}; INDEX_W index width.
// Revision    : 1.0 - initial release
// ============================================================================
module bdi_decompressor
    import bdi_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 2,
    parameter int INDEX_W         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic [MODE_W-1:0]     in_mode,
    input  logic [LINE_WORDS-1:0] in_base_sel,
    input  logic [INDEX_W-1:0]    in_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LINE_W-1:0]     out_line,
    output logic [INDEX_W-1:0]    out_index,
    output logic                  out_err
);

    localparam int c_GROUPS = LINE_WORDS / WORDS_PER_CYCLE;
    localparam int c_CNT_W  = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_GROUPS - 1);

    bdi_state_e            r_state;
    bdi_state_e            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [PAYLOAD_W-1:0]  r_payload;
    bdi_mode_e             r_mode;
    logic [LINE_WORDS-1:0] r_base_sel;
    logic [INDEX_W-1:0]    r_index;
    logic                  r_err;
    logic [LINE_W-1:0]     r_line;

    logic [3:0]            w_idx  [WORDS_PER_CYCLE];
    logic [WORD_W-1:0]     w_word [WORDS_PER_CYCLE];

    // ------------------------------------------------------------------
    // Word lanes: lane g decodes word r_cnt*WORDS_PER_CYCLE + g.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < WORDS_PER_CYCLE; g++) begin : g_lane
            assign w_idx[g] = 4'((int'(r_cnt) * WORDS_PER_CYCLE + g) % LINE_WORDS);

            bdi_word_lane u_lane (
                .i_payload  (r_payload),
                .i_mode     (r_mode),
                .i_base_sel (r_base_sel),
                .i_word_idx (w_idx[g]),
                .o_word     (w_word[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_state_nxt = EXPAND;
            EXPAND:  if (r_cnt == c_LAST) w_state_nxt = DONE;
            DONE:    if (out_ready)       w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // ------------------------------------------------------------------
    // Capture and expansion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_payload  <= '0;
            r_mode     <= BDI_ZERO;
            r_base_sel <= '0;
            r_index    <= '0;
            r_err      <= 1'b0;
            r_line     <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_payload  <= in_payload;
                        r_mode     <= mode_decode(in_mode);
                        r_base_sel <= in_base_sel;
                        r_index    <= in_index;
                        r_err      <= ~mode_legal(in_mode);
                        r_line     <= '0;
                        r_cnt      <= '0;
                    end
                end
                EXPAND: begin
                    for (int g = 0; g < WORDS_PER_CYCLE; g++) begin
                        r_line[{w_idx[g], 5'b00000} +: WORD_W] <= w_word[g];
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    // DONE holds the finished line stable.
                end
            endcase
        end
    end

    assign out_line  = r_line;
    assign out_index = r_index;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bdi_decompressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bdi_decompressor
// Description : Self-checking bench for bdi_decompressor. Expected lines are
//               produced by a behavioural model when a line is accepted and
//               compared by a monitor at each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bdi_decompressor;

    localparam int WPC = 2;
    localparam int IW  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [255:0]    in_payload = '0;
    logic [7:0]      in_mode = '0;
    logic [15:0]     in_base_sel = '0;
    logic [IW-1:0]   in_index = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [511:0]    out_line;
    logic [IW-1:0]   out_index;
    logic            out_err;

    bdi_decompressor #(
        .WORDS_PER_CYCLE (WPC),
        .INDEX_W         (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_mode     (in_mode),
        .in_base_sel (in_base_sel),
        .in_index    (in_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_line    (out_line),
        .out_index   (out_index),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0]  line;
        logic [IW-1:0] index;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            edge_cnt = 0;
    int            hs_cnt = 0;
    int            hs_edge = 0;
    int            first_valid_edge = 0;
    int            valid_run = 0;
    int            run_at_hs = 0;
    logic          prev_valid = 1'b0;
    logic [511:0]  last_line = '0;
    logic [IW-1:0] last_index = '0;
    logic          last_err = 1'b0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Behavioural reference: element-oriented, 64-bit results placed directly.
    function automatic exp_t model(input logic [255:0] p, input logic [7:0] m,
                                   input logic [15:0] bs, input logic [IW-1:0] idx);
        exp_t               r;
        logic [31:0]        b32;
        logic [63:0]        b64;
        logic [63:0]        v;
        logic signed [7:0]  d8;
        logic signed [15:0] d16;
        r.line  = '0;
        r.index = idx;
        r.err   = 1'b0;
        case (m)
            8'h01: r.line = '0;
            8'h02: for (int w = 0; w < 16; w++) r.line[32*w +: 32] = p[31:0];
            8'h04: for (int w = 0; w < 16; w++) begin
                b32 = bs[w] ? p[31:0] : 32'd0;
                d8  = p[32 + 8*w +: 8];
                r.line[32*w +: 32] = b32 + 32'(d8);
            end
            8'h08, 8'h10: for (int e = 0; e < 8; e++) begin
                b64 = bs[e] ? p[63:0] : 64'd0;
                if (m == 8'h08) begin
                    d8 = p[64 + 8*e +: 8];
                    v  = b64 + 64'(d8);
                end else begin
                    d16 = p[64 + 16*e +: 16];
                    v   = b64 + 64'(d16);
                end
                r.line[64*e +: 64] = v;
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            valid_run  = 0;
        end else begin
            if (out_valid) begin
                if (!prev_valid) first_valid_edge = edge_cnt;
                valid_run++;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_line", 1, 0);
                    end else begin
                        chk("sb_line",  out_line,  exp_q[0].line);
                        chk("sb_index", out_index, exp_q[0].index);
                        chk("sb_err",   out_err,   exp_q[0].err);
                        void'(exp_q.pop_front());
                    end
                    last_line  = out_line;
                    last_index = out_index;
                    last_err   = out_err;
                    run_at_hs  = valid_run;
                    valid_run  = 0;
                    hs_edge    = edge_cnt;
                    hs_cnt++;
                end
            end
            prev_valid = out_valid;
        end
    end

    // Call from just after a posedge. acc_edge = edge count of the accepting edge.
    task automatic send(input logic [255:0] p, input logic [7:0] m, input logic [15:0] bs,
                        input logic [IW-1:0] idx, output int acc_edge);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        acc_edge = 0;
        in_payload  = p;
        in_mode     = m;
        in_base_sel = bs;
        in_index    = idx;
        in_valid    = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            acc_edge = edge_cnt + 1;
            n++;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
        else exp_q.push_back(model(p, m, bs, idx));
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (hs_cnt < target) chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic at_edge(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

    initial begin
        int            a_edge;
        int            b_edge;
        int            h0;
        int            cnt;
        logic [255:0]  p;
        logic [7:0]    m;
        logic [7:0]    modes [6];

        modes[0] = 8'h01; modes[1] = 8'h02; modes[2] = 8'h04;
        modes[3] = 8'h08; modes[4] = 8'h10; modes[5] = 8'h21;

        // ---------------- Reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err",   out_err,   0);
        chk("rst_out_line",  out_line,  0);
        chk("rst_out_index", out_index, 0);
        @(posedge clk); #1;

        // ---------------- ZERO mode, latency ----------------
        out_ready = 1'b1;
        h0 = hs_cnt;
        send('1, 8'h01, 16'hFFFF, 10'h155, a_edge);
        wait_hs(h0 + 1);
        // Accept edge closes cycle 0; out_valid appears in cycle 16/WPC+1.
        chk("zero_latency_cycle", first_valid_edge - a_edge + 1, 9);
        chk("zero_valid_width",   run_at_hs, 1);
        chk("zero_line",          last_line, 0);
        chk("zero_index",         last_index, 10'h155);
        chk("zero_err",           last_err, 0);
        at_edge(hs_edge + 1);
        chk("zero_valid_drop",    out_valid, 0);
        chk("zero_ready_back",    in_ready, 1);
        @(posedge clk); #1;

        // ---------------- REPEAT ----------------
        p = '0;
        p[31:0] = 32'hDEADBEEF;
        p[255:32] = {7{32'h0BADF00D}};
        h0 = hs_cnt;
        send(p, 8'h02, 16'h0000, 10'h2A, a_edge);
        wait_hs(h0 + 1);
        chk("repeat_line", last_line, {16{32'hDEADBEEF}});
        @(posedge clk); #1;

        // ---------------- B4D1 ----------------
        p = '0;
        p[31:0] = 32'h10000000;
        for (int w = 0; w < 15; w++) p[32 + 8*w +: 8] = 8'(w);
        p[32 + 8*15 +: 8] = 8'hFF;
        h0 = hs_cnt;
        send(p, 8'h04, 16'hFFF7, 10'h3, a_edge);
        wait_hs(h0 + 1);
        chk("b4d1_word3",  last_line[32*3  +: 32], 32'h00000003);
        chk("b4d1_word5",  last_line[32*5  +: 32], 32'h10000005);
        chk("b4d1_word15", last_line[32*15 +: 32], 32'h0FFFFFFF);
        @(posedge clk); #1;

        // ---------------- B8D2 carry ----------------
        p = '0;
        p[63:0]  = 64'h00000001FFFFFFF0;
        p[79:64] = 16'h0020;
        p[95:80] = 16'hFFFF;
        h0 = hs_cnt;
        send(p, 8'h10, 16'h0001, 10'h7, a_edge);
        wait_hs(h0 + 1);
        chk("b8d2_word0", last_line[32*0 +: 32], 32'h00000010);
        chk("b8d2_word1", last_line[32*1 +: 32], 32'h00000002);
        chk("b8d2_word2", last_line[32*2 +: 32], 32'hFFFFFFFF);
        chk("b8d2_word3", last_line[32*3 +: 32], 32'hFFFFFFFF);
        @(posedge clk); #1;

        // ---------------- Backpressure ----------------
        out_ready = 1'b0;
        p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send(p, 8'h08, 16'h00A5, 10'h111, a_edge);
        // Next line offered during EXPAND/DONE must be ignored until IDLE.
        in_payload  = ~p;
        in_mode     = 8'h04;
        in_base_sel = 16'h5A5A;
        in_index    = 10'h222;
        in_valid    = 1'b1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_line",     out_line, exp_q[0].line);
            chk("bp_index",    out_index, 10'h111);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        h0 = hs_cnt;
        send(~p, 8'h04, 16'h5A5A, 10'h222, b_edge);
        // Handshake edge is hs_edge+1; re-accept exactly one edge later.
        chk("bp_reaccept_gap", b_edge - hs_edge - 1, 1);
        wait_hs(h0 + 2);
        @(posedge clk); #1;

        // ---------------- Illegal mode ----------------
        h0 = hs_cnt;
        send('1, 8'h06, 16'hFFFF, 10'h0F0, a_edge);
        wait_hs(h0 + 1);
        chk("illegal_latency_cycle", first_valid_edge - a_edge + 1, 9);
        chk("illegal_err",  last_err, 1);
        chk("illegal_line", last_line, 0);
        @(posedge clk); #1;

        // ---------------- Reset mid-EXPAND ----------------
        h0 = hs_cnt;
        send({8{32'h12345678}}, 8'h02, 16'h0, 10'h099, a_edge);
        // send returns in EXPAND cycle 1; move to cycle 4.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("abort_in_ready",  in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_err",   out_err, 0);
        chk("abort_out_line",  out_line, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_valid", cnt, 0);
        chk("abort_no_handshake", hs_cnt, h0);
        @(posedge clk); #1;

        // ---------------- Mixed random lines ----------------
        for (int k = 0; k < 12; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m = modes[k % 6];
            out_ready = 1'b0;
            h0 = hs_cnt;
            send(p, m, 16'($urandom), 10'($urandom), a_edge);
            wait_valid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
            wait_hs(h0 + 1);
            @(posedge clk); #1;
        end

        repeat (4) @(negedge clk);
        chk("sb_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
